// File: rtl/rv_instr_field_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_instr_field_decoder_pkg
// Description : RV32I opcode constants, format codes and the opcode-to-format
//               lookup shared by the instruction field decoder.
// Revision    : 1.0
// ============================================================================
package rv_instr_field_decoder_pkg;

    localparam logic [6:0] RISCV_OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] RISCV_OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] RISCV_OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] RISCV_OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] RISCV_OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] RISCV_OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] RISCV_OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] RISCV_OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] RISCV_OPCODE_OP     = 7'b0110011;

    localparam logic [2:0] FORMAT_R       = 3'd0;
    localparam logic [2:0] FORMAT_I       = 3'd1;
    localparam logic [2:0] FORMAT_S       = 3'd2;
    localparam logic [2:0] FORMAT_B       = 3'd3;
    localparam logic [2:0] FORMAT_U       = 3'd4;
    localparam logic [2:0] FORMAT_J       = 3'd5;
    localparam logic [2:0] FORMAT_UNKNOWN = 3'd7;

    // Compressed encodings (low bits != 2'b11) are never classified.
    function automatic logic [2:0] format_of(input logic [6:0] opcode);
        logic [2:0] fmt;
        fmt = FORMAT_UNKNOWN;
        if (opcode[1:0] == 2'b11) begin
            case (opcode)
                RISCV_OPCODE_OP:     fmt = FORMAT_R;
                RISCV_OPCODE_OP_IMM,
                RISCV_OPCODE_LOAD,
                RISCV_OPCODE_JALR:   fmt = FORMAT_I;
                RISCV_OPCODE_STORE:  fmt = FORMAT_S;
                RISCV_OPCODE_BRANCH: fmt = FORMAT_B;
                RISCV_OPCODE_LUI,
                RISCV_OPCODE_AUIPC:  fmt = FORMAT_U;
                RISCV_OPCODE_JAL:    fmt = FORMAT_J;
                default:             fmt = FORMAT_UNKNOWN;
            endcase
        end
        return fmt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_instr_field_decoder_sign_ext_12_32.sv
`default_nettype none
// ============================================================================
// Module      : sign_ext_12_32
// Description : Combinational 12-to-32 bit sign extender.
// Revision    : 1.0
// ============================================================================
module sign_ext_12_32 (
    input  logic [11:0] i_imm,
    output logic [31:0] o_ext
);

    assign o_ext = {{20{i_imm[11]}}, i_imm};

endmodule
`default_nettype wire

// File: rtl/rv_instr_field_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rv_instr_field_decoder
// Description : Registered RV32I instruction field decoder, one-cycle latency.
// Revision    : 1.0
// ============================================================================
module rv_instr_field_decoder
    import rv_instr_field_decoder_pkg::*;
(
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic        iwValid,
    input  logic [31:0] iwInstr,
    output logic        orValid,
    output logic [4:0]  orRs1,
    output logic [4:0]  orRs2,
    output logic [4:0]  orRd,
    output logic [6:0]  orOpCode,
    output logic [2:0]  orFunct3,
    output logic [6:0]  orFunct7,
    output logic [19:0] orImmediate20,
    output logic [11:0] orImmediate12,
    output logic [11:0] orImmediate12SClass,
    output logic [31:0] orImmediate12Extended,
    output logic [31:0] orImmediate12SClassExtended,
    output logic [31:0] orImmBExtended,
    output logic [31:0] orImmJExtended,
    output logic [2:0]  orFormat
);

    logic [11:0] w_imm_i;
    logic [11:0] w_imm_s;
    logic [31:0] w_imm_i_ext;
    logic [31:0] w_imm_s_ext;
    logic [31:0] w_imm_b_ext;
    logic [31:0] w_imm_j_ext;
    logic [2:0]  w_format;

    assign w_imm_i = iwInstr[31:20];
    assign w_imm_s = {iwInstr[31:25], iwInstr[11:7]};

    sign_ext_12_32 u_sext_i (
        .i_imm (w_imm_i),
        .o_ext (w_imm_i_ext)
    );

    sign_ext_12_32 u_sext_s (
        .i_imm (w_imm_s),
        .o_ext (w_imm_s_ext)
    );

    // Branch/jump offsets are halfword-aligned, so bit 0 is implicit zero.
    assign w_imm_b_ext = {{20{iwInstr[31]}}, iwInstr[7], iwInstr[30:25],
                          iwInstr[11:8], 1'b0};
    assign w_imm_j_ext = {{12{iwInstr[31]}}, iwInstr[19:12], iwInstr[20],
                          iwInstr[30:21], 1'b0};

    assign w_format = format_of(iwInstr[6:0]);

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            orValid                     <= 1'b0;
            orRs1                       <= '0;
            orRs2                       <= '0;
            orRd                        <= '0;
            orOpCode                    <= '0;
            orFunct3                    <= '0;
            orFunct7                    <= '0;
            orImmediate20               <= '0;
            orImmediate12               <= '0;
            orImmediate12SClass         <= '0;
            orImmediate12Extended       <= '0;
            orImmediate12SClassExtended <= '0;
            orImmBExtended              <= '0;
            orImmJExtended              <= '0;
            orFormat                    <= FORMAT_UNKNOWN;
        end else if (iwValid) begin
            orValid                     <= 1'b1;
            orRs1                       <= iwInstr[19:15];
            orRs2                       <= iwInstr[24:20];
            orRd                        <= iwInstr[11:7];
            orOpCode                    <= iwInstr[6:0];
            orFunct3                    <= iwInstr[14:12];
            orFunct7                    <= iwInstr[31:25];
            orImmediate20               <= iwInstr[31:12];
            orImmediate12               <= w_imm_i;
            orImmediate12SClass         <= w_imm_s;
            orImmediate12Extended       <= w_imm_i_ext;
            orImmediate12SClassExtended <= w_imm_s_ext;
            orImmBExtended              <= w_imm_b_ext;
            orImmJExtended              <= w_imm_j_ext;
            orFormat                    <= w_format;
        end else begin
            // Stall: fields keep the last decode for the consumer.
            orValid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_instr_field_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_instr_field_decoder
// Description : Scoreboard testbench for rv_instr_field_decoder.
// Revision    : 1.0
// ============================================================================
module tb_rv_instr_field_decoder;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [19:0] imm20;
        logic [11:0] imm12, imm12s;
        logic [31:0] imm12x, imm12sx, immb, immj;
        logic [2:0]  fmt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] instr;
    logic        o_valid;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [6:0]  o_opcode;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic [19:0] o_imm20;
    logic [11:0] o_imm12, o_imm12s;
    logic [31:0] o_imm12x, o_imm12sx, o_immb, o_immj;
    logic [2:0]  o_fmt;

    int   errors = 0;
    int   checks = 0;
    exp_t model;
    exp_t sb_q[$];

    rv_instr_field_decoder dut (
        .iwClk                       (clk),
        .iwRst                       (rst),
        .iwValid                     (valid),
        .iwInstr                     (instr),
        .orValid                     (o_valid),
        .orRs1                       (o_rs1),
        .orRs2                       (o_rs2),
        .orRd                        (o_rd),
        .orOpCode                    (o_opcode),
        .orFunct3                    (o_funct3),
        .orFunct7                    (o_funct7),
        .orImmediate20               (o_imm20),
        .orImmediate12               (o_imm12),
        .orImmediate12SClass         (o_imm12s),
        .orImmediate12Extended       (o_imm12x),
        .orImmediate12SClassExtended (o_imm12sx),
        .orImmBExtended              (o_immb),
        .orImmJExtended              (o_immj),
        .orFormat                    (o_fmt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decode built from the ISA field definitions with signed arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        logic [12:0] boff;
        logic [20:0] joff;
        e.valid   = 1'b1;
        e.rs1     = w[19:15];
        e.rs2     = w[24:20];
        e.rd      = w[11:7];
        e.opcode  = w[6:0];
        e.funct3  = w[14:12];
        e.funct7  = w[31:25];
        e.imm20   = w[31:12];
        e.imm12   = w[31:20];
        e.imm12s  = {w[31:25], w[11:7]};
        e.imm12x  = 32'($signed(e.imm12));
        e.imm12sx = 32'($signed(e.imm12s));
        boff      = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        joff      = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        e.immb    = 32'($signed(boff));
        e.immj    = 32'($signed(joff));
        if (w[1:0] != 2'b11) e.fmt = 3'd7;
        else begin
            case (w[6:0])
                7'h33:                e.fmt = 3'd0;
                7'h13, 7'h03, 7'h67: e.fmt = 3'd1;
                7'h23:                e.fmt = 3'd2;
                7'h63:                e.fmt = 3'd3;
                7'h37, 7'h17:        e.fmt = 3'd4;
                7'h6F:                e.fmt = 3'd5;
                default:              e.fmt = 3'd7;
            endcase
        end
        return e;
    endfunction

    // Drive one cycle, push the expected outcome, then pop and compare after the edge.
    task automatic step(input logic r, input logic v, input logic [31:0] w);
        exp_t e;
        rst   = r;
        valid = v;
        instr = w;
        if (r) begin
            model = '{default: '0};
            model.fmt = 3'd7;
        end else if (v) begin
            model = ref_decode(w);
        end else begin
            model.valid = 1'b0;
        end
        sb_q.push_back(model);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("valid",   32'(o_valid),   32'(e.valid));
            check("rs1",     32'(o_rs1),     32'(e.rs1));
            check("rs2",     32'(o_rs2),     32'(e.rs2));
            check("rd",      32'(o_rd),      32'(e.rd));
            check("opcode",  32'(o_opcode),  32'(e.opcode));
            check("funct3",  32'(o_funct3),  32'(e.funct3));
            check("funct7",  32'(o_funct7),  32'(e.funct7));
            check("imm20",   32'(o_imm20),   32'(e.imm20));
            check("imm12",   32'(o_imm12),   32'(e.imm12));
            check("imm12s",  32'(o_imm12s),  32'(e.imm12s));
            check("imm12x",  o_imm12x,       e.imm12x);
            check("imm12sx", o_imm12sx,      e.imm12sx);
            check("immb",    o_immb,         e.immb);
            check("immj",    o_immj,         e.immj);
            check("fmt",     32'(o_fmt),     32'(e.fmt));
        end
    endtask

    logic [6:0] op_list [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                                 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        instr = '0;
        model = '{default: '0};

        step(1'b1, 1'b0, 32'h0);
        check("rst_fmt", 32'(o_fmt), 32'd7);
        check("rst_valid", 32'(o_valid), 32'd0);

        step(1'b0, 1'b1, 32'hFFF10093);       // addi x1,x2,-1
        check("addi_rd", 32'(o_rd), 32'd1);
        check("addi_rs1", 32'(o_rs1), 32'd2);
        check("addi_imm12x", o_imm12x, 32'hFFFFFFFF);
        check("addi_fmt", 32'(o_fmt), 32'd1);

        step(1'b0, 1'b1, 32'h00532423);       // sw x5,8(x6)
        check("sw_rs1", 32'(o_rs1), 32'd6);
        check("sw_rs2", 32'(o_rs2), 32'd5);
        check("sw_imm12sx", o_imm12sx, 32'h00000008);
        check("sw_fmt", 32'(o_fmt), 32'd2);

        step(1'b0, 1'b1, 32'h12345537);       // lui x10,0x12345
        check("lui_rd", 32'(o_rd), 32'd10);
        check("lui_imm20", 32'(o_imm20), 32'h12345);
        check("lui_fmt", 32'(o_fmt), 32'd4);

        step(1'b0, 1'b1, 32'h00001517);       // auipc
        check("auipc_imm20", 32'(o_imm20), 32'h00001);
        check("auipc_fmt", 32'(o_fmt), 32'd4);

        step(1'b0, 1'b1, 32'hFE000EE3);       // beq x0,x0,-4
        check("beq_imm12s", 32'(o_imm12s), 32'hFFD);
        check("beq_immb", o_immb, 32'hFFFFFFFC);
        check("beq_fmt", 32'(o_fmt), 32'd3);

        step(1'b0, 1'b1, 32'h008000EF);       // jal x1,+8
        check("jal_rd", 32'(o_rd), 32'd1);
        check("jal_immj", o_immj, 32'h00000008);
        check("jal_fmt", 32'(o_fmt), 32'd5);

        step(1'b0, 1'b0, 32'hDEADBEEF);       // stall holds the jal decode
        check("stall_valid", 32'(o_valid), 32'd0);
        check("stall_immj", o_immj, 32'h00000008);

        step(1'b0, 1'b1, 32'h7FF00013);       // positive 12-bit boundary
        check("pos_imm12x", o_imm12x, 32'h000007FF);
        step(1'b0, 1'b1, 32'h80000013);       // negative 12-bit boundary
        check("neg_imm12x", o_imm12x, 32'hFFFFF800);

        step(1'b0, 1'b1, 32'h0000007F);
        check("unk_fmt", 32'(o_fmt), 32'd7);
        step(1'b0, 1'b1, 32'h00000030);       // opcode 0x30: OP with low bits 00
        check("low00_fmt", 32'(o_fmt), 32'd7);

        step(1'b1, 1'b1, 32'hFFF10093);       // reset beats valid
        check("rstv_fmt", 32'(o_fmt), 32'd7);
        check("rstv_imm12x", o_imm12x, 32'd0);
        check("rstv_valid", 32'(o_valid), 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[6:0] = op_list[$urandom_range(0, 9)];
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_instr_field_decoder.md
Name: rv_instr_field_decoder

Overview:
- Registered RV32I instruction field decoder for the ice-risc RISC-V path.
- Takes a raw 32-bit instruction word and produces, one clock later:
  - register indices, opcode, funct3, funct7;
  - raw 20-bit and 12-bit immediates;
  - 32-bit sign-extended I/S/B/J immediates;
  - an instruction-format class.
- Feeds the RV execute/control stage, which selects ALU, memory and next-PC controls from these fields.

Parameters:
- None. Widths are fixed by RV32I.

Ports:
- iwClk  input  1  clock; all state updates on rising edge.
- iwRst  input  1  synchronous, active-high reset.
- iwValid  input  1  iwInstr carries a valid instruction this cycle.
- iwInstr  input  32  raw instruction word.
- orValid  output  1  decoded outputs correspond to an instruction captured on the previous edge.
- orRs1  output  5  instr[19:15].
- orRs2  output  5  instr[24:20].
- orRd  output  5  instr[11:7].
- orOpCode  output  7  instr[6:0].
- orFunct3  output  3  instr[14:12].
- orFunct7  output  7  instr[31:25].
- orImmediate20  output  20  instr[31:12] (U-type upper immediate, raw).
- orImmediate12  output  12  instr[31:20] (I-type).
- orImmediate12SClass  output  12  {instr[31:25], instr[11:7]} (S-type).
- orImmediate12Extended  output  32  orImmediate12 sign-extended.
- orImmediate12SClassExtended  output  32  orImmediate12SClass sign-extended.
- orImmBExtended  output  32  sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- orImmJExtended  output  32  sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- orFormat  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=unknown.

Behaviour:
- Latency and pipelining:
  - Latency is exactly 1 cycle.
  - On each rising edge with iwRst=0 and iwValid=1, all field outputs are loaded from iwInstr and orValid<=1.
  - Throughput is one instruction per cycle.
- Stall: on an edge with iwRst=0 and iwValid=0, orValid<=0 and every other output holds its previous value.
- Reset:
  - On an edge with iwRst=1, all outputs go to 0, except orFormat<=7.
  - Reset has priority over iwValid.
  - Reset in mid-stream discards the instruction presented that cycle.
- Sign extension: the 12-bit immediate's bit 11 is replicated into bits 31:12.
  - 0x7FF -> 0x000007FF.
  - 0x800 -> 0xFFFFF800.
- B and J immediates: bit 0 is always 0; sign is instr[31].
- Format classification is by opcode. If instr[1:0]!=2'b11, format is 7 regardless of opcode.
  - 0110011 -> R.
  - 0010011, 0000011, 1100111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - Anything else -> 7.
- Field outputs are always extracted verbatim, whatever the format. Consumers ignore fields irrelevant to the format.
- No illegal-instruction checking on funct3/funct7; that belongs to the execute stage.

Decomposition:
- Shared package/include holds:
  - RISCV_OPCODE_* constants: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP;
  - FORMAT_* codes 0-5 and 7.
- One sub-module: sign_ext_12_32, a combinational 12-to-32 sign extender.
  - Instantiated twice: I-type and S-type.
  - B and J extension is done inline.
- Field slicing, format lookup and the output register stage live in the top module.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), valid -> next cycle:
  - orRd=1, orRs1=2, orOpCode=0x13, orFunct3=0;
  - orImmediate12=0xFFF, orImmediate12Extended=0xFFFFFFFF;
  - orFormat=1, orValid=1.
- sw x5,8(x6) (0x00532423) -> orRs1=6, orRs2=5, orFunct3=2, orImmediate12SClass=0x008, orImmediate12SClassExtended=0x00000008, orFormat=2.
- lui x10,0x12345 (0x12345537) -> orRd=10, orImmediate20=0x12345, orFormat=4. Follow with auipc (0x00001517) -> orFormat=4, orImmediate20=0x00001.
- beq x0,x0,-4 (0xFE000EE3) -> orImmediate12SClass=0xFFD, orImmBExtended=0xFFFFFFFC, orFormat=3.
- jal x1,+8 (0x008000EF) -> orRd=1, orImmJExtended=0x00000008, orFormat=5.
- Back-to-back stream, then iwValid=0 -> orValid=0 and fields hold the last decode.
- iwRst=1 with a valid instruction -> next edge all outputs 0, orFormat=7, orValid=0.
- Unknown opcode 0x0000007F -> orFormat=7.
- Instruction with instr[1:0]=2'b00 -> orFormat=7.
